// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: requester count,
// the zero-register address, the grant index type and 4-bit rotate helpers.
package wb_port_arbiter_pkg;

    localparam int NREQ = 4;
    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef logic [1:0] gnt_idx_t;

    // Rotate right by s: result bit j takes v[(j+s) mod 4], so bit s lands at 0.
    function automatic logic [3:0] rot_right4(input logic [3:0] v, input gnt_idx_t s);
        case (s)
            2'd0:    rot_right4 = v;
            2'd1:    rot_right4 = {v[0], v[3:1]};
            2'd2:    rot_right4 = {v[1:0], v[3:2]};
            2'd3:    rot_right4 = {v[2:0], v[3]};
            default: rot_right4 = v;
        endcase
    endfunction

    // Rotate left by s: undoes rot_right4 with the same shift amount.
    function automatic logic [3:0] rot_left4(input logic [3:0] v, input gnt_idx_t s);
        case (s)
            2'd0:    rot_left4 = v;
            2'd1:    rot_left4 = {v[2:0], v[3]};
            2'd2:    rot_left4 = {v[1:0], v[3:2]};
            2'd3:    rot_left4 = {v[0], v[3:1]};
            default: rot_left4 = v;
        endcase
    endfunction

endpackage

// File: rtl/wb_port_arbiter_pick.sv
// rr_pick4: combinational round-robin picker. The request vector is rotated so
// the highest-priority slot (ptr) sits at bit 0, a fixed lowest-bit-first pick
// is made, and the result is rotated back into requester numbering.
module rr_pick4
    import wb_port_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  gnt_idx_t   ptr,
    input  logic       en,
    output logic [3:0] gnt_onehot,
    output gnt_idx_t   gnt_id,
    output logic       any
);

    logic [3:0] rot_s;
    logic [3:0] pick_rot_s;
    gnt_idx_t   idx_rot_s;

    // Fixed-priority pick in the rotated domain, then map back to requester index.
    always_comb begin
        rot_s      = rot_right4(req, ptr);
        pick_rot_s = 4'b0000;
        idx_rot_s  = 2'd0;
        if (rot_s[0]) begin
            pick_rot_s = 4'b0001;
            idx_rot_s  = 2'd0;
        end else if (rot_s[1]) begin
            pick_rot_s = 4'b0010;
            idx_rot_s  = 2'd1;
        end else if (rot_s[2]) begin
            pick_rot_s = 4'b0100;
            idx_rot_s  = 2'd2;
        end else if (rot_s[3]) begin
            pick_rot_s = 4'b1000;
            idx_rot_s  = 2'd3;
        end else begin
            pick_rot_s = 4'b0000;
            idx_rot_s  = 2'd0;
        end

        if (en && (req != 4'b0000)) begin
            gnt_onehot = rot_left4(pick_rot_s, ptr);
            gnt_id     = idx_rot_s + ptr;
            any        = 1'b1;
        end else begin
            gnt_onehot = 4'b0000;
            gnt_id     = 2'd0;
            any        = 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port among four write-back
// requesters. One grant per non-stalled cycle, registered onto the port one
// cycle later; writes to the zero register are consumed without a write enable.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int N = 64,
    parameter int A = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [A-1:0]    req_addr0,
    input  logic [A-1:0]    req_addr1,
    input  logic [A-1:0]    req_addr2,
    input  logic [A-1:0]    req_addr3,
    input  logic [N-1:0]    req_data0,
    input  logic [N-1:0]    req_data1,
    input  logic [N-1:0]    req_data2,
    input  logic [N-1:0]    req_data3,
    output logic            wr_en,
    output logic [A-1:0]    wr_addr,
    output logic [N-1:0]    wr_data,
    output logic [1:0]      grant_id
);

    localparam logic [A-1:0] XZR_A = A'(XZR_ADDR);

    gnt_idx_t        ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [A-1:0]    wr_addr_q, wr_addr_d;
    logic [N-1:0]    wr_data_q, wr_data_d;
    gnt_idx_t        grant_id_q, grant_id_d;

    logic            pick_en_s;
    logic [NREQ-1:0] gnt_onehot_s;
    gnt_idx_t        gnt_id_s;
    logic            gnt_any_s;
    logic            xfer_s;
    logic [A-1:0]    sel_addr_s;
    logic [N-1:0]    sel_data_s;

    // No grants while stalled or while reset is held; a reset-cycle grant is discarded.
    assign pick_en_s = reset_n & ~stall;

    rr_pick4 u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .en         (pick_en_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_id     (gnt_id_s),
        .any        (gnt_any_s)
    );

    assign req_ready = gnt_onehot_s;
    assign xfer_s    = gnt_any_s & (|(req_valid & gnt_onehot_s));

    // Steer the granted requester's address and data toward the port register.
    always_comb begin
        sel_addr_s = req_addr0;
        sel_data_s = req_data0;
        case (gnt_id_s)
            2'd0: begin
                sel_addr_s = req_addr0;
                sel_data_s = req_data0;
            end
            2'd1: begin
                sel_addr_s = req_addr1;
                sel_data_s = req_data1;
            end
            2'd2: begin
                sel_addr_s = req_addr2;
                sel_data_s = req_data2;
            end
            2'd3: begin
                sel_addr_s = req_addr3;
                sel_data_s = req_data3;
            end
            default: begin
                sel_addr_s = req_addr0;
                sel_data_s = req_data0;
            end
        endcase
    end

    // Next state: load the port on a transfer (zero-register writes get no enable), else hold.
    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (xfer_s) begin
            ptr_d      = gnt_id_s + 2'd1;
            wr_en_d    = (sel_addr_s != XZR_A);
            wr_addr_d  = sel_addr_s;
            wr_data_d  = sel_data_s;
            grant_id_d = gnt_id_s;
        end else begin
            wr_en_d    = 1'b0;
        end
    end

    // Pointer and output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q      <= 2'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= 2'd0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: hand-written reset sequences, a
// directed vector table, and a randomized run against a behavioural model.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [4:0]  addr_v [4];
    logic [63:0] data_v [4];
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.N(64), .A(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (addr_v[0]),
        .req_addr1 (addr_v[1]),
        .req_addr2 (addr_v[2]),
        .req_addr3 (addr_v[3]),
        .req_data0 (data_v[0]),
        .req_data1 (data_v[1]),
        .req_data2 (data_v[2]),
        .req_data3 (data_v[3]),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    // Requester protocol monitor: a pending, unready request must stay put.
    logic        proto_on = 1'b0;
    logic        proto_prev = 1'b0;
    logic [3:0]  pv_q = 4'd0;
    logic [3:0]  pr_q = 4'd0;
    logic [4:0]  pa_q [4];
    logic [63:0] pd_q [4];

    always @(posedge clk) begin
        if (proto_on && proto_prev) begin
            for (int i = 0; i < 4; i++) begin
                if (pv_q[i] && !pr_q[i]) begin
                    assert (req_valid[i] && (addr_v[i] == pa_q[i]) && (data_v[i] == pd_q[i]))
                        else $error("requester %0d changed its request before ready", i);
                end
            end
        end
        pv_q       <= req_valid;
        pr_q       <= req_ready;
        proto_prev <= proto_on;
        for (int i = 0; i < 4; i++) begin
            pa_q[i] <= addr_v[i];
            pd_q[i] <= data_v[i];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Inputs are already applied; check ready mid-cycle, then the registered port after the edge.
    task automatic tick(input string nm, input logic [3:0] e_rdy, input logic e_en,
                        input logic [4:0] e_addr, input logic [63:0] e_data, input logic [1:0] e_gid);
        @(negedge clk);
        check({nm, ".ready"}, {60'd0, req_ready}, {60'd0, e_rdy});
        @(posedge clk);
        #1;
        check({nm, ".wr_en"},    {63'd0, wr_en},    {63'd0, e_en});
        check({nm, ".wr_addr"},  {59'd0, wr_addr},  {59'd0, e_addr});
        check({nm, ".wr_data"},  wr_data,           e_data);
        check({nm, ".grant_id"}, {62'd0, grant_id}, {62'd0, e_gid});
    endtask

    typedef struct {
        logic       stall;
        logic [3:0] valid;
        logic [4:0] addr2;
        logic [3:0] rdy;
        logic       en;
        logic [1:0] gid;
        logic [4:0] waddr;
    } vec_t;

    vec_t        tbl [19];
    logic [63:0] dconst [4];

    // Behavioural reference state for the random phase.
    int          m_ptr;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [1:0]  m_gid;

    initial begin
        dconst[0] = 64'hDEAD_BEEF_0000_0001;
        dconst[1] = 64'hDEAD_BEEF_0000_0002;
        dconst[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        dconst[3] = 64'h0123_4567_89AB_CDEF;

        //            stall  valid    addr2  ready    en    gid   waddr
        tbl[0]  = '{1'b0, 4'b1111, 5'd3,  4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[1]  = '{1'b0, 4'b1111, 5'd3,  4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[2]  = '{1'b0, 4'b1111, 5'd3,  4'b0100, 1'b1, 2'd2, 5'd3};
        tbl[3]  = '{1'b0, 4'b1111, 5'd3,  4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[4]  = '{1'b0, 4'b1111, 5'd3,  4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[5]  = '{1'b0, 4'b0010, 5'd3,  4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[6]  = '{1'b0, 4'b0011, 5'd3,  4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[7]  = '{1'b0, 4'b0011, 5'd3,  4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[8]  = '{1'b0, 4'b0100, 5'd31, 4'b0100, 1'b0, 2'd2, 5'd31};
        tbl[9]  = '{1'b0, 4'b0000, 5'd31, 4'b0000, 1'b0, 2'd2, 5'd31};
        tbl[10] = '{1'b1, 4'b0100, 5'd3,  4'b0000, 1'b0, 2'd2, 5'd31};
        tbl[11] = '{1'b1, 4'b0100, 5'd3,  4'b0000, 1'b0, 2'd2, 5'd31};
        tbl[12] = '{1'b1, 4'b0100, 5'd3,  4'b0000, 1'b0, 2'd2, 5'd31};
        tbl[13] = '{1'b0, 4'b0100, 5'd3,  4'b0100, 1'b1, 2'd2, 5'd3};
        tbl[14] = '{1'b0, 4'b0000, 5'd3,  4'b0000, 1'b0, 2'd2, 5'd3};
        tbl[15] = '{1'b0, 4'b1001, 5'd3,  4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[16] = '{1'b0, 4'b1001, 5'd3,  4'b0001, 1'b1, 2'd0, 5'd1};
        tbl[17] = '{1'b0, 4'b1111, 5'd3,  4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[18] = '{1'b1, 4'b1111, 5'd3,  4'b0000, 1'b0, 2'd1, 5'd2};

        for (int i = 0; i < 4; i++) begin
            addr_v[i] = 5'(i + 1);
            data_v[i] = dconst[i];
        end

        // Reset held two cycles with all requesters pending: no grants.
        #1;
        stall     = 1'b0;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        tick("rst_a", 4'b0000, 1'b0, 5'd0, 64'd0, 2'd0);
        tick("rst_b", 4'b0000, 1'b0, 5'd0, 64'd0, 2'd0);
        reset_n = 1'b1;
        tick("rst_rel", 4'b0001, 1'b1, 5'd1, dconst[0], 2'd0);

        // Return to pointer 0 before the vector table.
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        tick("rst_c", 4'b0000, 1'b0, 5'd0, 64'd0, 2'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            stall     = tbl[i].stall;
            req_valid = tbl[i].valid;
            addr_v[2] = tbl[i].addr2;
            tick($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].waddr,
                 dconst[tbl[i].gid], tbl[i].gid);
        end

        // Reset in the cycle requester 1 would be granted: discarded, then re-granted.
        stall     = 1'b0;
        addr_v[2] = 5'd3;
        req_valid = 4'b0010;
        reset_n   = 1'b0;
        tick("mid_rst", 4'b0000, 1'b0, 5'd0, 64'd0, 2'd0);
        reset_n = 1'b1;
        tick("mid_rel", 4'b0010, 1'b1, 5'd2, dconst[1], 2'd1);
        req_valid = 4'b0000;
        tick("mid_idle", 4'b0000, 1'b0, 5'd2, dconst[1], 2'd1);

        // Randomized run against the reference model, starting from reset.
        reset_n   = 1'b0;
        stall     = 1'b0;
        req_valid = 4'b0000;
        tick("rnd_rst", 4'b0000, 1'b0, 5'd0, 64'd0, 2'd0);
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = 5'd0;
        m_data = 64'd0;
        m_gid  = 2'd0;
        proto_on = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            int         g;
            logic [3:0] e_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 0)) begin
                    req_valid[i] = 1'b1;
                    addr_v[i]    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                    data_v[i]    = {$urandom(), $urandom()};
                end
            end
            stall   = ($urandom_range(0, 4) == 0);
            reset_n = ($urandom_range(0, 49) != 0);

            g = -1;
            if (reset_n && !stall) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            e_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;

            if (!reset_n) begin
                m_ptr  = 0;
                m_en   = 1'b0;
                m_addr = 5'd0;
                m_data = 64'd0;
                m_gid  = 2'd0;
            end else if (g >= 0) begin
                m_en   = (addr_v[g] != 5'd31);
                m_addr = addr_v[g];
                m_data = data_v[g];
                m_gid  = 2'(g);
                m_ptr  = (g + 1) % 4;
            end else begin
                m_en = 1'b0;
            end

            tick($sformatf("rnd%0d", c), e_rdy, m_en, m_addr, m_data, m_gid);
            if (g >= 0) req_valid[g] = 1'b0;
        end

        proto_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
